// File: rtl/mem_req_queue.sv
// rtl/mem_req_queue.sv - in-order miss request FIFO feeding a fixed-latency memory model
module mem_req_queue #(
  parameter int TAG_WIDTH   = 8,
  parameter int INDEX_WIDTH = 4,
  parameter int DATA_WIDTH  = 16,
  parameter int NUM_OPS     = 32,
  parameter int QUEUE_DEPTH = 4,
  parameter int MEM_LATENCY = 4,
  parameter int DATA_OFFSET = 'h1000
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [TAG_WIDTH+INDEX_WIDTH-1:0]   mm_req,
  input  logic [$clog2(NUM_OPS)-1:0]         mm_req_operation,
  input  logic                               mm_req_valid,
  output logic [DATA_WIDTH-1:0]              mm_ret_data,
  output logic [$clog2(NUM_OPS)-1:0]         mm_ret_operation,
  output logic                               mm_ret_valid,
  output logic                               queue_full,
  output logic [$clog2(QUEUE_DEPTH+1)-1:0]   queue_count,
  output logic                               busy,
  output logic                               overflow
);

  localparam int ADDR_W = TAG_WIDTH + INDEX_WIDTH;
  localparam int OP_W   = $clog2(NUM_OPS);
  localparam int CNT_W  = $clog2(QUEUE_DEPTH + 1);
  localparam int PTR_W  = $clog2(QUEUE_DEPTH);
  localparam int LAT_W  = $clog2(MEM_LATENCY + 1);
  localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(MEM_LATENCY - 1);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESP} state_t;

  state_t            state, state_nxt;
  logic [LAT_W-1:0]  lat_cnt, lat_cnt_nxt;
  logic              pop, push, resp_load;
  logic              fifo_empty, fifo_full;

  logic [ADDR_W-1:0] fifo_addr [QUEUE_DEPTH];
  logic [OP_W-1:0]   fifo_op   [QUEUE_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  count;

  logic [ADDR_W-1:0]     svc_addr;
  logic [OP_W-1:0]       svc_op;
  logic [DATA_WIDTH-1:0] svc_addr_ext;

  assign fifo_empty  = (count == '0);
  assign fifo_full   = (count == CNT_W'(QUEUE_DEPTH));
  // A full queue still takes a request when the head leaves in the same cycle.
  assign push        = mm_req_valid && (!fifo_full || pop);

  assign queue_full  = fifo_full;
  assign queue_count = count;
  assign busy        = (state != S_IDLE);

  generate
    if (ADDR_W >= DATA_WIDTH) begin : g_addr_trunc
      assign svc_addr_ext = svc_addr[DATA_WIDTH-1:0];
    end else begin : g_addr_zext
      assign svc_addr_ext = {{(DATA_WIDTH-ADDR_W){1'b0}}, svc_addr};
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_IDLE;
      lat_cnt <= '0;
    end else begin
      state   <= state_nxt;
      lat_cnt <= lat_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    lat_cnt_nxt = lat_cnt;
    pop         = 1'b0;
    resp_load   = 1'b0;
    case (state)
      S_IDLE: begin
        if (!fifo_empty) begin
          pop         = 1'b1;
          lat_cnt_nxt = LAT_LOAD;
          state_nxt   = S_BUSY;
        end
      end
      S_BUSY: begin
        if (lat_cnt == '0) begin
          resp_load = 1'b1;
          state_nxt = S_RESP;
        end else begin
          lat_cnt_nxt = lat_cnt - 1'b1;
        end
      end
      S_RESP: begin
        // Chain straight into the next service to avoid an idle bubble.
        if (!fifo_empty) begin
          pop         = 1'b1;
          lat_cnt_nxt = LAT_LOAD;
          state_nxt   = S_BUSY;
        end else begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[wr_ptr] <= mm_req;
      fifo_op[wr_ptr]   <= mm_req_operation;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr           <= '0;
      rd_ptr           <= '0;
      count            <= '0;
      svc_addr         <= '0;
      svc_op           <= '0;
      overflow         <= 1'b0;
      mm_ret_valid     <= 1'b0;
      mm_ret_data      <= '0;
      mm_ret_operation <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr   <= rd_ptr + 1'b1;
        svc_addr <= fifo_addr[rd_ptr];
        svc_op   <= fifo_op[rd_ptr];
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (mm_req_valid && fifo_full && !pop) overflow <= 1'b1;
      // Return registers are loaded on entry to RESP so the pulse lines up with that state.
      mm_ret_valid <= resp_load;
      if (resp_load) begin
        mm_ret_data      <= svc_addr_ext + DATA_WIDTH'(DATA_OFFSET);
        mm_ret_operation <= svc_op;
      end
    end
  end

endmodule

// File: doc/mem_req_queue.md
# mem_req_queue

Downstream memory stage for the non-blocking cache. It accepts miss fetch requests issued by the MSHR (`mm_req`, `mm_req_operation`, `mm_req_valid`) and buffers them in an in-order FIFO. It services them one at a time with a fixed main-memory latency and returns the data to the MSHR on `mm_ret_data`, `mm_ret_operation` and `mm_ret_valid`. Returned data is a deterministic function of the address, so the cache can be simulated and synthesized without a backing array.

## Interface
- TAG_WIDTH, 8, tag bits of a request address
- INDEX_WIDTH, 4, index bits of a request address
- DATA_WIDTH, 16, width of a returned line word
- NUM_OPS, 32, operation-ID space; ID width is $clog2(NUM_OPS)
- QUEUE_DEPTH, 4, FIFO entries; power of 2, ≥2
- MEM_LATENCY, 4, service cycles per request; ≥1
- DATA_OFFSET, 'h1000, constant added to the address to form return data
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-low reset (0 = reset)
- mm_req  in  TAG_WIDTH+INDEX_WIDTH  request address {tag,index}
- mm_req_operation  in  $clog2(NUM_OPS)  operation ID of the request
- mm_req_valid  in  1  request present this cycle
- mm_ret_data  out  DATA_WIDTH  returned data
- mm_ret_operation  out  $clog2(NUM_OPS)  operation ID of the returned data
- mm_ret_valid  out  1  one-cycle return pulse
- queue_full  out  1  count == QUEUE_DEPTH
- queue_count  out  $clog2(QUEUE_DEPTH+1)  entries queued, excluding the one in service
- busy  out  1  FSM not IDLE
- overflow  out  1  sticky: a request was dropped

## Operation
**FIFO**
- Circular buffer with read/write pointers that wrap modulo QUEUE_DEPTH.
- Each entry holds {address, op ID}.
- Enqueue on every cycle with `mm_req_valid`=1 when not full.
- When full, a request is still accepted if a pop occurs in the same cycle. The count is then unchanged.
- When full with no pop, the request is dropped and `overflow` is set. `overflow` stays set until reset.
- The MSHR has no backpressure input. Correct integration requires QUEUE_DEPTH+1 ≥ NUM_MISSES.

**FSM states**
- IDLE: if the FIFO is non-empty, pop the head into the service register, load the counter with MEM_LATENCY-1, and go to BUSY.
- BUSY: if the counter is 0, go to RESP; otherwise decrement the counter.
- RESP: drive `mm_ret_valid`=1 with the service register contents.
  - If the FIFO is non-empty, pop the next entry in the same cycle and go directly to BUSY (no IDLE bubble).
  - Otherwise go to IDLE.

**Data and ordering**
- Return data is (zero-extended address + DATA_OFFSET) mod 2^DATA_WIDTH. If the address is wider than DATA_WIDTH, use its low DATA_WIDTH bits.
- Responses are strictly in request order.
- An entry enqueued in the cycle the FIFO is empty cannot be popped in that same cycle.

## Timing
- All outputs are registered.
- `queue_full` and `busy` are decoded from registered state only.
- Reset values: every output 0, FSM in IDLE, pointers, count and counter 0.
- Reset is asynchronous: asserting `rst` mid-operation clears outputs immediately. All queued and in-service requests are discarded, and no response is issued for them after release.
- Latency, uncontended: a request sampled at the end of cycle 0 is popped at the end of cycle 1. It occupies BUSY for cycles 2 through MEM_LATENCY+1, and `mm_ret_valid` pulses in cycle MEM_LATENCY+2.
- Throughput: one response every MEM_LATENCY+1 cycles under back-to-back load.
- `mm_ret_valid` is high for exactly one cycle per response.
- `mm_ret_data` and `mm_ret_operation` update only in RESP and hold their last values otherwise.
- `queue_count` reflects enqueue and pop from the previous edge; simultaneous enqueue and pop leaves it unchanged.

## Test plan
All scenarios use the default parameters.
- **Reset:** hold `rst`=0 for 2 cycles with `mm_req_valid`=1 → all outputs 0 and nothing enqueued. After release, `queue_count`=0 and `busy`=0.
- **Single request:** `mm_req`={36,4'b1010}=586, op 9, in cycle 0 → `mm_ret_valid` in cycle 6 only, `mm_ret_data`=0x124A, `mm_ret_operation`=9. `busy` is high in cycles 2–6.
- **Back-to-back:** ops 9, 10, 11, 12 in cycles 0–3 with addresses 586, 68, 119, 255 → returns in order in cycles 6, 11, 16, 21. Data is 0x124A, 0x1044, 0x1077, 0x10FF. `queue_count` after cycles 0–3 is 1, 1, 2, 3. `overflow`=0.
- **Overflow:** 6 requests, ops 1–6, in cycles 0–5 → `queue_full`=1 from cycle 5. Op 6 is dropped and `overflow`=1 from cycle 6. Ops 1–5 return at cycles 6, 11, 16, 21, 26; op 6 never returns.
- **Full with simultaneous pop:** continuing the overflow scenario, present op 7 in cycle 6 (RESP with FIFO full) → op 7 is accepted, `queue_count` stays 4, and op 7 returns in cycle 31 after op 5.
- **Reset mid-operation:** issue op 9 in cycle 0 and assert `rst` in cycle 3 → outputs are 0 immediately, and no `mm_ret_valid` appears within 20 cycles after release.
